// File: rtl/aes_mem_sched_pkg.sv
// Shared constants and types for the AES memory scheduler.
// Contents: memory/AES geometry, derived widths, scheduler state enum and
// a base-address range check used when a start request is accepted.
package aes_mem_sched_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int MEM_DEPTH  = 64;
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);
    localparam int N          = 128;
    localparam int Nr         = 10;
    localparam int WPB        = N / DATA_WIDTH;
    localparam int ROUND_W    = $clog2(Nr + 1);
    localparam int WIDX_W     = $clog2(WPB);
    localparam int MAX_BASE   = MEM_DEPTH - WPB;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        DRAIN,
        LOAD,
        ROUND,
        CAPT,
        WR,
        DONE
    } sched_state_e;

    // A block base is legal only if all WPB words fit without wrapping.
    function automatic logic base_ok(input logic [ADDR_WIDTH-1:0] base);
        return base <= ADDR_WIDTH'(MAX_BASE);
    endfunction

endpackage

// File: rtl/aes_mem_sched_if.sv
// Memory and AES-core bus between the scheduler and the datapath.
// master: scheduler side (drives strobes/address/write data/core controls,
//         receives read data and core state).
// slave : datapath side (memory + round-based AES core).
interface aes_mem_sched_if import aes_mem_sched_pkg::*; ();

    logic                  mem_rd_en;
    logic                  mem_wr_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  aes_load;
    logic [N-1:0]          aes_state_in;
    logic                  aes_round_en;
    logic [ROUND_W-1:0]    aes_round_idx;
    logic                  aes_last_round;
    logic [N-1:0]          aes_state_out;

    modport master (
        output mem_rd_en, mem_wr_en, mem_addr, mem_wr_data,
        output aes_load, aes_state_in, aes_round_en, aes_round_idx, aes_last_round,
        input  mem_rd_data, aes_state_out
    );

    modport slave (
        input  mem_rd_en, mem_wr_en, mem_addr, mem_wr_data,
        input  aes_load, aes_state_in, aes_round_en, aes_round_idx, aes_last_round,
        output mem_rd_data, aes_state_out
    );

endinterface

// File: rtl/aes_mem_sched_word_packer.sv
// aes_word_packer: gathers 32-bit memory words into a 128-bit block (word 0
// ends up as the MSW) and scatters a captured 128-bit result into words.
// Ports:
//   clk, rst    clock, async active-high reset
//   shift_en    shift word_in into the low end of the gather register
//   word_in     read word to gather
//   block_next  gather register with word_in appended (complete block on last shift)
//   capt_en     latch result_in into the result buffer
//   result_in   128-bit core state
//   word_idx    which result word to present, 0 = MSW
//   word_out    selected result word
module aes_word_packer
    import aes_mem_sched_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] word_in,
    output logic [N-1:0]          block_next,
    input  logic                  capt_en,
    input  logic [N-1:0]          result_in,
    input  logic [WIDX_W-1:0]     word_idx,
    output logic [DATA_WIDTH-1:0] word_out
);

    logic [N-1:0] gather_q;
    logic [N-1:0] result_q;

    assign block_next = {gather_q[N-DATA_WIDTH-1:0], word_in};
    assign word_out   = result_q[N-1-DATA_WIDTH*int'(word_idx) -: DATA_WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gather_q <= '0;
            result_q <= '0;
        end else begin
            if (shift_en) gather_q <= block_next;
            if (capt_en)  result_q <= result_in;
        end
    end

endmodule

// File: rtl/aes_mem_sched.sv
// aes_mem_sched: runs one AES-128 encryption between the shared register
// memory and the round-based core: gather 4 words, load, Nr rounds, capture,
// scatter 4 words, pulse done.
// Ports:
//   clk, rst            clock, async active-high reset
//   start               one-cycle request (honoured in IDLE only)
//   src_addr, dst_addr  first plaintext / ciphertext word address
//   busy                high while an operation is in flight (through DONE)
//   done                one-cycle completion pulse
//   err                 one-cycle pulse after a rejected start
//   bus                 memory + AES core bus (master side)
//
// state | meaning
// IDLE  | waiting for start
// RD    | read src+k, k=0..WPB-1
// DRAIN | last read word returns
// LOAD  | present gathered block to core
// ROUND | core rounds 1..Nr
// CAPT  | latch core result
// WR    | write dst+k, k=0..WPB-1
// DONE  | completion pulse
module aes_mem_sched
    import aes_mem_sched_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    aes_mem_sched_if.master       bus
);

    sched_state_e          state, state_nxt;
    logic [ROUND_W-1:0]    tmr, tmr_nxt;
    logic [ADDR_WIDTH-1:0] src_q, dst_q;
    logic [N-1:0]          state_in_q;
    logic [N-1:0]          block_next;
    logic [DATA_WIDTH-1:0] word_out;
    logic [WIDX_W-1:0]     widx;
    logic                  accept;

    // Down-counter runs WPB-1..0 in RD/WR; word index counts up from it.
    assign widx   = WIDX_W'(WPB - 1) - tmr[WIDX_W-1:0];
    assign accept = (state == IDLE) && start && base_ok(src_addr) && base_ok(dst_addr);

    aes_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .shift_en   (((state == RD) && (widx != '0)) || (state == DRAIN)),
        .word_in    (bus.mem_rd_data),
        .block_next (block_next),
        .capt_en    (state == CAPT),
        .result_in  (bus.aes_state_out),
        .word_idx   (widx),
        .word_out   (word_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tmr        <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            err        <= 1'b0;
            state_in_q <= '0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
            err   <= (state == IDLE) && start && !accept;
            if (accept) begin
                src_q <= src_addr;
                dst_q <= dst_addr;
            end
            // Separate hold register keeps aes_state_in stable while the
            // gather register refills during the next operation.
            if (state == DRAIN) state_in_q <= block_next;
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_nxt   = (tmr != '0) ? tmr - 1'b1 : tmr;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = RD;
                    tmr_nxt   = ROUND_W'(WPB - 1);
                end
            end
            RD:    if (tmr == '0) state_nxt = DRAIN;
            DRAIN: state_nxt = LOAD;
            LOAD: begin
                state_nxt = ROUND;
                tmr_nxt   = ROUND_W'(Nr - 1);
            end
            ROUND: if (tmr == '0) state_nxt = CAPT;
            CAPT: begin
                state_nxt = WR;
                tmr_nxt   = ROUND_W'(WPB - 1);
            end
            WR:    if (tmr == '0) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy               = (state != IDLE);
        done               = (state == DONE);
        bus.mem_rd_en      = (state == RD);
        bus.mem_wr_en      = (state == WR);
        bus.mem_addr       = '0;
        bus.mem_wr_data    = '0;
        bus.aes_load       = (state == LOAD);
        bus.aes_state_in   = state_in_q;
        bus.aes_round_en   = (state == ROUND);
        bus.aes_round_idx  = '0;
        bus.aes_last_round = (state == ROUND) && (tmr == '0);
        if (state == RD) bus.mem_addr = src_q + ADDR_WIDTH'(widx);
        if (state == WR) begin
            bus.mem_addr    = dst_q + ADDR_WIDTH'(widx);
            bus.mem_wr_data = word_out;
        end
        if (state == ROUND) bus.aes_round_idx = ROUND_W'(Nr) - tmr;
    end

endmodule

// File: tb/tb_aes_mem_sched.sv
// Directed bench for aes_mem_sched with a behavioural memory and a stub AES
// core that returns the FIPS-197 C.1 ciphertext after the last round.
module tb_aes_mem_sched;
    import aes_mem_sched_pkg::*;

    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [5:0] src_addr = '0;
    logic [5:0] dst_addr = '0;
    logic       busy, done, err;

    aes_mem_sched_if bus ();

    aes_mem_sched dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:63];

    always @(posedge clk) begin
        if (bus.mem_wr_en) mem[bus.mem_addr] = bus.mem_wr_data;
        if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];
    end

    always @(posedge clk) begin
        if (bus.aes_load)
            bus.aes_state_out <= '0;
        else if (bus.aes_round_en && bus.aes_last_round)
            bus.aes_state_out <= CT;
    end

    int n_chk = 0;
    int n_err = 0;

    logic         lg_busy [1:31];
    logic         lg_done [1:31];
    logic         lg_err  [1:31];
    logic         lg_rd   [1:31];
    logic         lg_wr   [1:31];
    logic         lg_load [1:31];
    logic         lg_ren  [1:31];
    logic         lg_last [1:31];
    logic [5:0]   lg_addr [1:31];
    logic [31:0]  lg_wdat [1:31];
    logic [3:0]   lg_idx  [1:31];
    logic [127:0] lg_sin  [1:31];

    int n_done, first_done, n_errp, n_rd, first_rd, last_rd, n_wr, first_wr, last_wr;
    int n_load, load_cyc, n_ren, busy_cnt, overlap;
    logic [23:0] rd_seq, wr_seq;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue a start at the next edge, then log ncyc cycles (cycle 1 = first
    // cycle after the accepting edge). inj>0 pulses a second start in cycle inj.
    task automatic run_op(input logic [5:0] s, input logic [5:0] d, input int ncyc, input int inj);
        start = 1'b1; src_addr = s; dst_addr = d;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            lg_busy[c] = busy;          lg_done[c] = done;
            lg_err[c]  = err;           lg_rd[c]   = bus.mem_rd_en;
            lg_wr[c]   = bus.mem_wr_en; lg_load[c] = bus.aes_load;
            lg_ren[c]  = bus.aes_round_en; lg_last[c] = bus.aes_last_round;
            lg_addr[c] = bus.mem_addr;  lg_wdat[c] = bus.mem_wr_data;
            lg_idx[c]  = bus.aes_round_idx; lg_sin[c] = bus.aes_state_in;
            if (c == inj) begin start = 1'b1; src_addr = 6'd4; dst_addr = 6'd4; end
            if (c == inj + 1) start = 1'b0;
            @(posedge clk); #1;
        end
        n_done = 0; first_done = -1; n_errp = 0; n_rd = 0; first_rd = -1; last_rd = -1;
        n_wr = 0; first_wr = -1; last_wr = -1; n_load = 0; load_cyc = -1; n_ren = 0;
        busy_cnt = 0; overlap = 0; rd_seq = '0; wr_seq = '0;
        for (int c = 1; c <= ncyc; c++) begin
            if (lg_done[c]) begin n_done++; if (first_done < 0) first_done = c; end
            if (lg_err[c]) n_errp++;
            if (lg_rd[c]) begin
                n_rd++; if (first_rd < 0) first_rd = c; last_rd = c;
                rd_seq = {rd_seq[17:0], lg_addr[c]};
            end
            if (lg_wr[c]) begin
                n_wr++; if (first_wr < 0) first_wr = c; last_wr = c;
                wr_seq = {wr_seq[17:0], lg_addr[c]};
            end
            if (lg_load[c]) begin n_load++; load_cyc = c; end
            if (lg_ren[c]) n_ren++;
            if (lg_busy[c]) busy_cnt++;
            if (lg_rd[c] && lg_wr[c]) overlap++;
        end
    endtask

    task automatic preload(input int base, input logic [127:0] blk);
        for (int i = 0; i < 4; i++) mem[base + i] = blk[127 - 32*i -: 32];
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hdead_0000 | i;
        preload(0, PT);

        // Reset state
        #12;
        chk("rst_busy",  128'(busy), 128'(0));
        chk("rst_done",  128'(done), 128'(0));
        chk("rst_err",   128'(err),  128'(0));
        chk("rst_strobes", 128'({bus.mem_rd_en, bus.mem_wr_en, bus.aes_load, bus.aes_round_en, bus.aes_last_round}), 128'(0));
        chk("rst_addr",  128'(bus.mem_addr), 128'(0));
        chk("rst_wdata", 128'(bus.mem_wr_data), 128'(0));
        chk("rst_idx",   128'(bus.aes_round_idx), 128'(0));
        chk("rst_sin",   bus.aes_state_in, 128'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic encrypt, src=0 dst=8
        run_op(6'd0, 6'd8, 24, 0);
        chk("t1_done_cyc", 128'(first_done), 128'(22));
        chk("t1_n_done",   128'(n_done), 128'(1));
        chk("t1_busy_cnt", 128'(busy_cnt), 128'(22));
        chk("t1_busy_23",  128'(lg_busy[23]), 128'(0));
        chk("t1_rd_seq",   128'(rd_seq), 128'({6'd0, 6'd1, 6'd2, 6'd3}));
        chk("t1_rd_cyc",   128'({8'(first_rd), 8'(last_rd), 8'(n_rd)}), 128'({8'd1, 8'd4, 8'd4}));
        chk("t1_load",     128'({8'(n_load), 8'(load_cyc)}), 128'({8'd1, 8'd6}));
        chk("t1_sin",      lg_sin[6], PT);
        chk("t1_sin_hold", lg_sin[12], PT);
        chk("t1_n_rounds", 128'(n_ren), 128'(10));
        for (int c = 7; c <= 16; c++) begin
            chk("t1_round_en",  128'(lg_ren[c]), 128'(1));
            chk("t1_round_idx", 128'(lg_idx[c]), 128'(c - 6));
            chk("t1_last",      128'(lg_last[c]), 128'(c == 16));
        end
        chk("t1_wr_seq",   128'(wr_seq), 128'({6'd8, 6'd9, 6'd10, 6'd11}));
        chk("t1_wr_cyc",   128'({8'(first_wr), 8'(last_wr), 8'(n_wr)}), 128'({8'd18, 8'd21, 8'd4}));
        chk("t1_wdat_0",   128'(lg_wdat[17]), 128'(0));
        chk("t1_wdat_18",  128'(lg_wdat[18]), 128'(32'h69c4e0d8));
        chk("t1_overlap",  128'(overlap), 128'(0));
        chk("t1_mem",      {mem[8], mem[9], mem[10], mem[11]}, CT);

        // Highest legal base
        preload(60, PT);
        run_op(6'd60, 6'd0, 24, 0);
        chk("t2_rd_seq",   128'(rd_seq), 128'({6'd60, 6'd61, 6'd62, 6'd63}));
        chk("t2_done_cyc", 128'(first_done), 128'(22));
        chk("t2_sin",      lg_sin[6], PT);
        chk("t2_mem",      {mem[0], mem[1], mem[2], mem[3]}, CT);

        // src out of range
        run_op(6'd61, 6'd0, 4, 0);
        chk("t3_err_1",  128'(lg_err[1]), 128'(1));
        chk("t3_err_2",  128'(lg_err[2]), 128'(0));
        chk("t3_no_rd",  128'(n_rd), 128'(0));
        chk("t3_busy",   128'(busy_cnt), 128'(0));

        // dst out of range
        run_op(6'd0, 6'd63, 4, 0);
        chk("t4_err_1",  128'(lg_err[1]), 128'(1));
        chk("t4_n_err",  128'(n_errp), 128'(1));
        chk("t4_no_acc", 128'(n_rd + n_wr + busy_cnt), 128'(0));

        // In place, src=dst=20
        preload(20, PT);
        run_op(6'd20, 6'd20, 24, 0);
        chk("t5_sin",      lg_sin[6], PT);
        chk("t5_rd_first", 128'(last_rd < first_wr), 128'(1));
        chk("t5_wr_seq",   128'(wr_seq), 128'({6'd20, 6'd21, 6'd22, 6'd23}));
        chk("t5_mem",      {mem[20], mem[21], mem[22], mem[23]}, CT);

        // Start while busy is ignored
        preload(0, PT);
        run_op(6'd0, 6'd30, 26, 10);
        chk("t6_n_done",   128'(n_done), 128'(1));
        chk("t6_done_cyc", 128'(first_done), 128'(22));
        chk("t6_n_err",    128'(n_errp), 128'(0));
        chk("t6_n_rd",     128'(n_rd), 128'(4));
        chk("t6_busy_24",  128'(lg_busy[24]), 128'(0));
        chk("t6_mem",      {mem[30], mem[31], mem[32], mem[33]}, CT);

        // Reset during cycle 19 (second write)
        preload(40, 128'ha0a0a0a0_a1a1a1a1_a2a2a2a2_a3a3a3a3);
        start = 1'b1; src_addr = 6'd0; dst_addr = 6'd40;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (18) begin @(posedge clk); #1; end
        chk("t7_wr_19",   128'({bus.mem_wr_en, bus.mem_addr}), 128'({1'b1, 6'd41}));
        #2 rst = 1'b1;
        #1;
        chk("t7_busy",    128'(busy), 128'(0));
        chk("t7_strobes", 128'({bus.mem_wr_en, bus.mem_rd_en, done, err}), 128'(0));
        chk("t7_addr",    128'({bus.mem_addr, bus.mem_wr_data}), 128'(0));
        chk("t7_sin",     bus.aes_state_in, 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("t7_mem40",   128'(mem[40]), 128'(32'h69c4e0d8));
        chk("t7_mem41",   128'(mem[41]), 128'(32'ha1a1a1a1));
        chk("t7_mem42_43", 128'({mem[42], mem[43]}), 128'(64'ha2a2a2a2_a3a3a3a3));

        // Fresh start after reset
        run_op(6'd0, 6'd44, 24, 0);
        chk("t8_done_cyc", 128'(first_done), 128'(22));
        chk("t8_sin",      lg_sin[6], PT);
        chk("t8_mem",      {mem[44], mem[45], mem[46], mem[47]}, CT);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/aes_mem_sched.md
Name: aes_mem_sched

Overview:
- Sequences one iterative AES-128 encryption between the shared 64x32 register memory and the round-based AES core.
- On start, gathers 4 words (128 bits) from memory and loads them into the core.
- Steps the core through Nr rounds, then scatters the 4-word result back to memory and pulses done.
- Sits between the UART command decoder (start/addresses) and the memory/AES datapath.

Parameters:
- DATA_WIDTH, 32, memory word width (shared package value)
- MEM_DEPTH, 64, memory depth in words
- ADDR_WIDTH, $clog2(MEM_DEPTH), memory address width
- N, 128, AES block width in bits
- Nr, 10, number of AES rounds
- WPB, N/DATA_WIDTH (4), words per AES block

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle request, sampled in IDLE only
- src_addr  in  ADDR_WIDTH  first plaintext word address
- dst_addr  in  ADDR_WIDTH  first ciphertext word address
- busy  out  1  high from the cycle after accepted start through the DONE cycle
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse on rejected start
- mem_rd_en  out  1  memory read strobe (read data valid on the next cycle)
- mem_wr_en  out  1  memory write strobe
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wr_data  out  DATA_WIDTH  memory write data
- mem_rd_data  in  DATA_WIDTH  memory read data
- aes_load  out  1  load aes_state_in; core performs round-0 AddRoundKey
- aes_state_in  out  N  plaintext block
- aes_round_en  out  1  execute one round
- aes_round_idx  out  4  current round number, 1..Nr
- aes_last_round  out  1  high with round Nr (core skips MixColumns)
- aes_state_out  in  N  core state; valid the cycle after the last round

Behaviour:
- Reset: asynchronous, active-high. Every output is 0, state is IDLE, internal buffers clear. Reset asserted mid-operation aborts the operation with no further memory writes; a partial write already done stays in memory.
- States: IDLE -> RD -> DRAIN -> LOAD -> ROUND -> CAPT -> WR -> DONE -> IDLE.
- IDLE:
  - start=1 with src_addr<=MEM_DEPTH-WPB and dst_addr<=MEM_DEPTH-WPB: latch both addresses, go to RD.
  - start=1 otherwise: err=1 for the next cycle, stay IDLE, no memory access.
- RD (WPB cycles, counter k=0..3): mem_rd_en=1, mem_addr=src+k. Data returned for word k is stored at block bits [N-1-32k -: 32], i.e. word 0 is the MSW.
- DRAIN (1 cycle): capture the last read word; mem_rd_en=0.
- LOAD (1 cycle): aes_load=1, aes_state_in=gathered block.
- ROUND (Nr cycles):
  - aes_round_en=1 and aes_round_idx=1..Nr on consecutive cycles.
  - aes_last_round=1 only when idx==Nr.
- CAPT (1 cycle): latch aes_state_out into the result buffer.
- WR (WPB cycles, k=0..3): mem_wr_en=1, mem_addr=dst+k, mem_wr_data=result[N-1-32k -: 32].
- DONE (1 cycle): done=1, then IDLE. busy=0 in the IDLE cycle that follows.
- Latency: start accepted at edge 0 gives reads in cycles 1-4, LOAD in 6, rounds in 7-16, writes in 18-21, done in 22. The next start can be accepted in cycle 23.
- Ordering and overlap:
  - start while busy is ignored (no err, no restart).
  - src and dst ranges may overlap, including src==dst; all reads complete before any write.
- Strobe rules: aes_state_in holds its value outside LOAD. mem_wr_data is 0 when mem_wr_en=0. mem_rd_en and mem_wr_en are never high together.
- Address arithmetic is ADDR_WIDTH-bit. The range check guarantees no wrap-around, so src=60 is legal and src=61 gives err.

Decomposition:
- global_pkg adds:
  - WPB = N/DATA_WIDTH
  - ROUND_W = $clog2(Nr+1)
  - enum sched_state_e {IDLE,RD,DRAIN,LOAD,ROUND,CAPT,WR,DONE}
  - MAX_BASE = MEM_DEPTH-WPB
- One sub-module is natural: aes_word_packer, which gathers 32-bit words into a 128-bit block (shift-in) and scatters the 128-bit result into words by index. The FSM and counters stay in aes_mem_sched.

Test Plan:
- Basic encrypt:
  - Stimulus: mem[0..3]=00112233,44556677,8899aabb,ccddeeff; stub core returns the FIPS-197 C.1 result; start src=0, dst=8.
  - Required: mem[8..11]=69c4e0d8,6a7b0430,d8cdb780,70b4c55a; done exactly at cycle 22; busy high in cycles 1-22.
- Address bounds:
  - start src=60, dst=0 -> accepted; reads of addresses 60-63 observed.
  - start src=61 -> err pulse the next cycle, no mem_rd_en, busy stays 0.
  - start dst=63 -> err.
- Round sequencing: check that aes_load fires once in cycle 6, aes_round_idx steps 1..10 in cycles 7-16, and aes_last_round is high only at idx 10.
- In-place operation: src=dst=20 -> all 4 reads precede the first write; mem[20..23] end holding the result.
- Start while busy: pulse start again at cycle 10 with src=4 -> ignored; one done only; no err.
- Reset mid-op: assert rst during cycle 19 -> outputs 0 immediately; mem[dst+2] and mem[dst+3] unchanged; a fresh start after release completes normally.
